// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned divider: restoring algorithm, one quotient bit per clock.
// Results are registered on entry to DONE and held until the next completed operation.
module div8_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quot,
  output logic [7:0] rem,
  output logic       dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [8:0] r_q;
  logic [7:0] q_q;
  logic [7:0] div_q;
  logic [2:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] quot_q;
  logic [7:0] rem_q;
  logic       dz_q;

  logic [8:0] t_d;
  logic [8:0] diff_d;
  logic [8:0] r_d;
  logic [7:0] q_d;

  // The partial remainder stays below the divisor, so its top bit is always clear.
  logic       unused_rem_msb;
  assign unused_rem_msb = r_q[8];

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    t_d    = {r_q[7:0], q_q[7]};
    diff_d = t_d - {1'b0, div_q};
    if (t_d >= {1'b0, div_q}) begin
      r_d = diff_d;
      q_d = {q_q[6:0], 1'b1};
    end else begin
      r_d = t_d;
      q_d = {q_q[6:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= 9'd0;
      q_q     <= 8'd0;
      div_q   <= 8'd0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 8'd0;
      rem_q   <= 8'd0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (divisor != 8'd0) begin
              state_q <= CALC;
              q_q     <= dividend;
              div_q   <= divisor;
              r_q     <= 9'd0;
              cnt_q   <= 3'd0;
            end else begin
              // Divide by zero skips the iterations and reports immediately.
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= 8'hFF;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d[7:0];
            dz_q    <= 1'b0;
          end else begin
            done_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Scoreboard bench for div8_seq: directed corner cases plus random operands
// checked against plain a/b, a%b arithmetic.
module tb_div8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quot;
  logic [7:0] rem;
  logic       dz;

  int checks = 0;
  int fails  = 0;

  // Expected {quot, rem, dz} per issued operation, in issue order.
  logic [16:0] exp_q[$];
  logic [7:0]  last_quot = 8'd0;
  logic [7:0]  last_rem  = 8'd0;
  logic        last_dz   = 1'b0;

  always #5 clk = ~clk;

  div8_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .dz       (dz)
  );

  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return {8'hFF, a, 1'b1};
    return {a / b, a % b, 1'b0};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  logic [16:0] mon_e;
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("quot", quot, mon_e[16:9]);
        check("rem",  rem,  mon_e[8:1]);
        check("dz",   dz,   mon_e[0]);
      end
    end
  end

  // Count cycles after the accepting edge until done; outputs must hold meanwhile.
  task automatic wait_done(input int lat, input logic [16:0] e);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        check("busy_calc", busy, 1);
        check("hold_quot", quot, last_quot);
        check("hold_rem",  rem,  last_rem);
        check("hold_dz",   dz,   last_dz);
      end
    end while (!done && n < 20);
    check("latency", n, lat);
    check("busy_at_done", busy, 1);
    last_quot = e[16:9];
    last_rem  = e[8:1];
    last_dz   = e[0];
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    logic [16:0] e;
    e = model(a, b);
    @(negedge clk);
    check("idle_busy", busy, 0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    wait_done((b == 8'd0) ? 1 : 9, e);
  endtask

  initial begin
    logic [16:0] e1;
    logic [16:0] e2;
    logic [7:0]  ra;
    logic [7:0]  rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quot, 0);
    check("rst_rem",  rem,  0);
    check("rst_dz",   dz,   0);
    rst = 1'b0;

    do_op(8'd200, 8'd7);
    do_op(8'd255, 8'd1);
    do_op(8'd255, 8'd255);
    do_op(8'd5,   8'd9);
    do_op(8'd0,   8'd3);
    do_op(8'd17,  8'd0);
    do_op(8'd10,  8'd3);

    // start held high through a whole operation, then reused back-to-back
    e1 = model(8'd100, 8'd3);
    @(negedge clk);
    check("idle_busy", busy, 0);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd3;
    exp_q.push_back(e1);
    @(posedge clk);
    #1;
    dividend = 8'd50;
    divisor  = 8'd5;
    wait_done(9, e1);
    e2 = model(8'd50, 8'd5);
    exp_q.push_back(e2);
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(9, e2);

    // reset in cycle 4 of an operation aborts it silently
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quot", quot, 0);
    check("abort_rem",  rem,  0);
    check("abort_dz",   dz,   0);
    repeat (12) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    last_quot = 8'd0;
    last_rem  = 8'd0;
    last_dz   = 1'b0;
    do_op(8'd9, 8'd2);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
      do_op(ra, rb);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
